// File: rtl/cf_fft_pkg.sv
// cf_fft_pkg: shared phase encoding and helper functions for the FFT address sequencer
package cf_fft_pkg;
  typedef enum logic [1:0] {
    PH_IDLE    = 2'd0,
    PH_LOAD    = 2'd1,
    PH_COMPUTE = 2'd2,
    PH_UNLOAD  = 2'd3
  } phase_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < w; i++) r[i] = v[w-1-i];
    return r;
  endfunction
endpackage

// File: rtl/cf_fft_addr_gen_if.sv
// cf_fft_addr_gen_if: control inputs and address/control tuple outputs of the FFT sequencer
interface cf_fft_addr_gen_if import cf_fft_pkg::*; #(
  parameter int LOG2_N = 10
);
  localparam int SW = clog2(LOG2_N);
  logic              clear;
  logic              enable;
  logic              start;
  logic              inverse;
  logic              busy;
  phase_t            phase;
  logic [SW-1:0]     stage;
  logic [LOG2_N-1:0] addr_a;
  logic [LOG2_N-1:0] addr_b;
  logic [LOG2_N-2:0] tw_idx;
  logic              tw_conj;
  logic              out_valid;
  logic              done;

  modport master (
    output clear, enable, start, inverse,
    input  busy, phase, stage, addr_a, addr_b, tw_idx, tw_conj, out_valid, done
  );

  modport slave (
    input  clear, enable, start, inverse,
    output busy, phase, stage, addr_a, addr_b, tw_idx, tw_conj, out_valid, done
  );
endinterface

// File: rtl/cf_fft_bitrev.sv
// cf_fft_bitrev: combinational W-bit bit reversal
module cf_fft_bitrev import cf_fft_pkg::*; #(
  parameter int W = 10
) (
  input  logic [W-1:0] x,
  output logic [W-1:0] y
);
  assign y = W'(bitrev(32'(x), W));
endmodule

// File: rtl/cf_fft_addr_gen.sv
// cf_fft_addr_gen: load / butterfly / unload address and twiddle sequencer for an in-place radix-2 DIT FFT
module cf_fft_addr_gen import cf_fft_pkg::*; #(
  parameter int LOG2_N = 10,
  parameter int ADDR_W = LOG2_N
) (
  input logic              clock_c,
  input logic              reset,
  cf_fft_addr_gen_if.slave bus
);
  localparam int SW = clog2(LOG2_N);
  localparam logic [ADDR_W-1:0] CNT_LAST  = '1;
  localparam logic [ADDR_W-1:0] BFLY_LAST = ADDR_W'((1 << (LOG2_N - 1)) - 1);
  localparam logic [SW-1:0]     STG_LAST  = SW'(LOG2_N - 1);

  phase_t              state, state_nxt, phase_q, phase_nxt;
  logic [ADDR_W-1:0]   cnt, cnt_nxt;
  logic [SW-1:0]       stg, stg_nxt, stage_q, stage_nxt;
  logic                conj, conj_nxt;
  logic [ADDR_W-1:0]   rev, span, pos, grp, bf_a;
  logic [LOG2_N-2:0]   bf_tw;
  logic [ADDR_W-1:0]   a_q, a_nxt, b_q, b_nxt;
  logic [LOG2_N-2:0]   tw_q, tw_nxt;
  logic                busy_q, busy_nxt, valid_q, valid_nxt, done_q, done_nxt;
  logic                idle_o, upd;

  cf_fft_bitrev #(.W(ADDR_W)) u_rev (.x(cnt), .y(rev));

  assign span  = ADDR_W'(1) << stg;
  assign pos   = cnt & (span - ADDR_W'(1));
  assign grp   = cnt >> stg;
  assign bf_a  = ((grp << stg) << 1) | pos;
  assign bf_tw = (LOG2_N - 1)'(pos << (STG_LAST - stg));

  // state and output registers; outputs are registered copies of the next tuple
  always_ff @(posedge clock_c or posedge reset)
    if (reset) begin
      state   <= PH_IDLE;
      cnt     <= '0;
      stg     <= '0;
      conj    <= 1'b0;
      busy_q  <= 1'b0;
      phase_q <= PH_IDLE;
      stage_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      tw_q    <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      stg     <= stg_nxt;
      conj    <= conj_nxt;
      busy_q  <= busy_nxt;
      phase_q <= phase_nxt;
      stage_q <= stage_nxt;
      a_q     <= a_nxt;
      b_q     <= b_nxt;
      tw_q    <= tw_nxt;
      valid_q <= valid_nxt;
      done_q  <= done_nxt;
    end

  // next state: clear aborts, start leaves IDLE, enable advances counters with phase wraps
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stg_nxt   = stg;
    conj_nxt  = conj;
    if (bus.clear) begin
      state_nxt = PH_IDLE;
      cnt_nxt   = '0;
      stg_nxt   = '0;
      conj_nxt  = 1'b0;
    end else if (state == PH_IDLE) begin
      if (bus.start) begin
        state_nxt = PH_LOAD;
        cnt_nxt   = '0;
        stg_nxt   = '0;
        conj_nxt  = bus.inverse;
      end
    end else if (bus.enable) begin
      cnt_nxt = cnt + ADDR_W'(1);
      if (state == PH_LOAD && cnt == CNT_LAST) state_nxt = PH_COMPUTE;
      if (state == PH_COMPUTE && cnt == BFLY_LAST) begin
        cnt_nxt = '0;
        stg_nxt = stg == STG_LAST ? '0 : stg + SW'(1);
        state_nxt = stg == STG_LAST ? PH_UNLOAD : PH_COMPUTE;
      end
      if (state == PH_UNLOAD && cnt == CNT_LAST) state_nxt = PH_IDLE;
    end
  end

  // next tuple: zero when idle or clearing, hold when stalled, else the tuple for cnt
  always_comb begin
    idle_o    = bus.clear || state == PH_IDLE;
    upd       = !idle_o && bus.enable;
    busy_nxt  = !bus.clear && (state != PH_IDLE || state_nxt != PH_IDLE);
    valid_nxt = upd;
    done_nxt  = upd && state == PH_UNLOAD && cnt == CNT_LAST;
    phase_nxt = idle_o ? PH_IDLE : upd ? state : phase_q;
    stage_nxt = idle_o ? '0 : !upd ? stage_q : state == PH_COMPUTE ? stg : '0;
    a_nxt     = idle_o ? '0 : !upd ? a_q : state == PH_LOAD ? rev : state == PH_COMPUTE ? bf_a : cnt;
    b_nxt     = idle_o ? '0 : !upd ? b_q : state == PH_COMPUTE ? bf_a + span : '0;
    tw_nxt    = idle_o ? '0 : !upd ? tw_q : state == PH_COMPUTE ? bf_tw : '0;
  end

  assign bus.busy      = busy_q;
  assign bus.phase     = phase_q;
  assign bus.stage     = stage_q;
  assign bus.addr_a    = a_q;
  assign bus.addr_b    = b_q;
  assign bus.tw_idx    = tw_q;
  assign bus.tw_conj   = conj;
  assign bus.out_valid = valid_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_cf_fft_addr_gen.sv
// tb_cf_fft_addr_gen: scoreboard bench for the FFT address sequencer at LOG2_N=3
module tb_cf_fft_addr_gen;
  import cf_fft_pkg::*;
  localparam int N = 3;

  typedef struct {
    int ph, st, a, b, tw, cj, dn;
  } tup_t;

  logic clock_c = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   vcnt = 0;
  int   dcnt = 0;
  tup_t q[$];
  int   ld[8]  = '{0, 4, 2, 6, 1, 5, 3, 7};
  int   ca[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int   cb[12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int   ct[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  cf_fft_addr_gen_if #(.LOG2_N(N)) bus ();

  cf_fft_addr_gen #(.LOG2_N(N), .ADDR_W(N)) dut (
    .clock_c(clock_c),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clock_c = ~clock_c;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int packt(input tup_t t);
    return (t.ph << 24) | (t.st << 20) | (t.a << 16) | (t.b << 12) | (t.tw << 8) | (t.cj << 4) | t.dn;
  endfunction

  function automatic int outs();
    return int'({bus.busy, bus.phase, bus.stage, bus.addr_a, bus.addr_b, bus.tw_idx,
                 bus.tw_conj, bus.out_valid, bus.done});
  endfunction

  task automatic push(input int ph, input int st, input int a, input int b, input int tw,
                      input int cj, input int dn);
    tup_t t;
    t = '{ph, st, a, b, tw, cj, dn};
    q.push_back(t);
  endtask

  task automatic push_run(input int cj, input int nl, input int nc, input int nu);
    for (int i = 0; i < nl; i++) push(1, 0, ld[i], 0, 0, cj, 0);
    for (int k = 0; k < nc; k++) push(2, k / 4, ca[k], cb[k], ct[k], cj, 0);
    for (int i = 0; i < nu; i++) push(3, 0, i, 0, 0, cj, int'(i == 7));
  endtask

  task automatic run_to_done(output int n);
    n = 0;
    do begin
      @(negedge clock_c);
      bus.start = 1'b0;
      n++;
    end while (!bus.done && n < 200);
    chk("done_seen", bus.done, 1);
    chk("busy_at_done", bus.busy, 1);
  endtask

  task automatic wait_tuple(input int ph, input int st, input int a);
    int n;
    n = 0;
    do begin
      @(negedge clock_c);
      bus.start = 1'b0;
      n++;
    end while (!(bus.out_valid && int'(bus.phase) == ph && int'(bus.stage) == st &&
                 int'(bus.addr_a) == a) && n < 200);
    chk("tuple_reached", int'(n < 200), 1);
  endtask

  // monitor: pop the expected tuple whenever the DUT presents one
  always @(negedge clock_c) begin
    tup_t e, a;
    chk("done_implies_valid", int'(bus.done & ~bus.out_valid), 0);
    if (bus.out_valid) begin
      vcnt++;
      if (bus.done) dcnt++;
      a = '{int'(bus.phase), int'(bus.stage), int'(bus.addr_a), int'(bus.addr_b),
            int'(bus.tw_idx), int'(bus.tw_conj), int'(bus.done)};
      if (q.size() == 0) chk("unexpected_tuple", packt(a), 0);
      else begin
        e = q.pop_front();
        chk("tuple", packt(a), packt(e));
      end
    end
  end

  initial begin
    int n, v0, d0;
    bus.clear = 1'b0;
    bus.enable = 1'b0;
    bus.start = 1'b0;
    bus.inverse = 1'b0;
    repeat (2) @(negedge clock_c);
    chk("reset_outputs", outs(), 0);
    reset = 1'b0;
    @(negedge clock_c);
    chk("idle_outputs", outs(), 0);
    // full forward run with enable held high
    push_run(0, 8, 12, 8);
    v0 = vcnt;
    bus.enable = 1'b1;
    bus.start = 1'b1;
    run_to_done(n);
    chk("cycles_to_done", n, 29);
    @(negedge clock_c);
    chk("busy_after_done", bus.busy, 0);
    chk("valid_after_done", bus.out_valid, 0);
    chk("run1_tuples", vcnt - v0, 28);
    chk("run1_queue", q.size(), 0);
    // enable stalls during compute
    push_run(0, 8, 12, 8);
    v0 = vcnt;
    bus.start = 1'b1;
    wait_tuple(2, 0, 0);
    chk("en_t0", bus.out_valid, 1);
    bus.enable = 1'b0;
    @(negedge clock_c);
    chk("en_t1", bus.out_valid, 0);
    @(negedge clock_c);
    chk("en_t2", bus.out_valid, 0);
    bus.enable = 1'b1;
    @(negedge clock_c);
    chk("en_t3", bus.out_valid, 1);
    run_to_done(n);
    @(negedge clock_c);
    chk("run2_tuples", vcnt - v0, 28);
    chk("run2_queue", q.size(), 0);
    // clear after two stage-1 tuples
    push_run(0, 8, 6, 0);
    v0 = vcnt;
    d0 = dcnt;
    bus.start = 1'b1;
    wait_tuple(2, 1, 1);
    bus.clear = 1'b1;
    @(negedge clock_c);
    chk("clear_busy", bus.busy, 0);
    chk("clear_valid", bus.out_valid, 0);
    chk("clear_outputs", outs(), 0);
    bus.clear = 1'b0;
    repeat (3) @(negedge clock_c);
    chk("clear_tuples", vcnt - v0, 14);
    chk("clear_no_done", dcnt - d0, 0);
    chk("clear_stays_idle", bus.busy, 0);
    // start together with clear in IDLE is ignored
    bus.clear = 1'b1;
    bus.start = 1'b1;
    @(negedge clock_c);
    bus.clear = 1'b0;
    bus.start = 1'b0;
    chk("start_clear_busy", bus.busy, 0);
    @(negedge clock_c);
    chk("start_clear_idle", outs(), 0);
    // inverse run with a start pulse while busy
    push_run(1, 8, 12, 8);
    v0 = vcnt;
    bus.inverse = 1'b1;
    bus.start = 1'b1;
    @(negedge clock_c);
    bus.start = 1'b0;
    bus.inverse = 1'b0;
    chk("conj_latched", bus.tw_conj, 1);
    chk("busy_after_start", bus.busy, 1);
    repeat (3) @(negedge clock_c);
    bus.start = 1'b1;
    @(negedge clock_c);
    bus.start = 1'b0;
    chk("conj_kept", bus.tw_conj, 1);
    run_to_done(n);
    @(negedge clock_c);
    chk("run4_tuples", vcnt - v0, 28);
    chk("run4_queue", q.size(), 0);
    // asynchronous reset mid-load
    push_run(0, 3, 0, 0);
    bus.start = 1'b1;
    wait_tuple(1, 0, 2);
    #2 reset = 1'b1;
    #1 chk("async_reset_outputs", outs(), 0);
    @(negedge clock_c);
    reset = 1'b0;
    @(negedge clock_c);
    chk("reset_queue", q.size(), 0);
    chk("reset_idle", bus.busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cf_fft_addr_gen.md
Name: cf_fft_addr_gen

Overview:
Parametrised address and control sequencer for an in-place radix-2 DIT FFT engine with 2^LOG2_N points.
Generalises the single-bit enable/clear state cell used in the generated FFT netlists into a full multi-bit sequencer. It emits one address tuple per enabled cycle over three phases: bit-reversed load, butterfly compute with twiddle index, and natural-order unload.
Sits between the FFT top-level control and the dual-port sample RAM / twiddle ROM.

Parameters:
LOG2_N, 10, log2 of transform length; legal range 2..12
ADDR_W, LOG2_N, sample address width; must equal LOG2_N

Ports:
clock_c  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
clear  input  1  synchronous abort; highest priority after reset
enable  input  1  advance/stall; sequencer holds when low
start  input  1  begin a transform; sampled only in IDLE
inverse  input  1  inverse-transform request; latched on accepted start
busy  output  1  high whenever state is not IDLE
phase  output  2  phase of the current tuple: 0 idle, 1 load, 2 compute, 3 unload
stage  output  ceil(log2(LOG2_N))  compute stage of the current tuple; 0 outside compute
addr_a  output  ADDR_W  load/unload address, or butterfly top address
addr_b  output  ADDR_W  butterfly bottom address; 0 outside compute
tw_idx  output  LOG2_N-1  twiddle ROM index; 0 outside compute
tw_conj  output  1  latched inverse; consumer conjugates the twiddle
out_valid  output  1  tuple on the outputs is valid this cycle
done  output  1  one-cycle pulse coincident with the final unload tuple

Behaviour:
- Reset (async) and clear (sync) force the same state: IDLE, all counters 0, all outputs 0 (busy, phase, stage, addr_a, addr_b, tw_idx, tw_conj, out_valid, done).
- FSM states:
  - IDLE: start=1 -> LOAD, counter=0, latch inverse. No tuple is emitted on that edge.
  - LOAD: emits 2^LOG2_N tuples, addr_a = bitrev(cnt).
  - COMPUTE: LOG2_N stages of 2^(LOG2_N-1) butterflies each.
  - UNLOAD: emits 2^LOG2_N tuples, addr_a = cnt.
  - After the last UNLOAD tuple -> IDLE.
- Compute arithmetic, stage s, butterfly b: span = 2^s; pos = b & (span-1); grp = b >> s.
  - addr_a = (grp << (s+1)) | pos
  - addr_b = addr_a + span
  - tw_idx = pos << (LOG2_N-1-s)
  - All values are unsigned, with no overflow by construction.
- Timing:
  - All outputs are registered.
  - On each edge with state not IDLE and enable=1: the tuple for the current counter is registered, out_valid goes to 1 next cycle, and the counter advances.
  - On an edge with enable=0: out_valid=0 and the counter holds. Held address outputs keep their last value.
- Counter wrap:
  - butterfly counter wraps at 2^(LOG2_N-1)-1, incrementing stage.
  - stage LOG2_N-1 with last butterfly -> UNLOAD.
  - load/unload counters wrap at 2^LOG2_N-1 and move to the next phase.
- Throughput: exactly 2^(LOG2_N+1) + LOG2_N*2^(LOG2_N-1) enabled cycles per transform. There are no bubbles at phase boundaries.
- done=1 and out_valid=1 appear together on the final unload tuple; busy drops on the following cycle.
- start while busy: ignored; inverse is not re-latched.
- start and clear on the same edge: clear wins, state stays IDLE.
- clear mid-operation: abort in one cycle; done is not asserted.
- start and enable on the same IDLE edge: only the transition happens; the first tuple needs a further enabled edge.
- Reset asserted mid-operation: outputs go to 0 immediately (asynchronous). Release is synchronised externally.

Decomposition:
- Shared package cf_fft_pkg:
  - phase enum (IDLE/LOAD/COMPUTE/UNLOAD with the encodings above)
  - constant function clog2
  - function bitrev(value, width)
- One sub-module, cf_fft_bitrev: combinational, parameter W, reverses W bits. It is instantiated for the load address and is reusable by the data path.

Test Plan:
- LOG2_N=3, reset, start, enable held high -> load addr_a sequence 0,4,2,6,1,5,3,7, with phase=1 and out_valid on each.
- Same run, compute phase:
  - stage0: (0,1),(2,3),(4,5),(6,7), tw 0,0,0,0
  - stage1: (0,2),(1,3),(4,6),(5,7), tw 0,2,0,2
  - stage2: (0,4),(1,5),(2,6),(3,7), tw 0,1,2,3
- Same run, unload addr_a = 0..7; done high only with addr_a=7; total 28 valid tuples; busy low on the next cycle.
- Toggle enable 1,0,0,1 during compute -> out_valid 1,0,0,1; no tuple skipped or repeated; total valid count still 28.
- Assert clear in stage1 after 2 tuples -> next cycle busy=0, out_valid=0, done never asserted. Then start with inverse=1 -> tw_conj=1 for the whole run.
- Assert start while busy, and start together with clear in IDLE -> both ignored; async reset asserted mid-load zeroes all outputs before the next edge.
